bp_predecoder: RTL

- Fetch-stage predecoder with dynamic branch prediction.
- Expands RVC instructions, classifies control flow and produces next_pc in the same cycle.
- Predicts conditional branches with a parametrised table of 2-bit saturating counters, trained by ROB commit updates.
- Holds fetch on unresolved JALR via a small wait FSM; an optional return-address stack predicts returns instead of stalling.

---
 rtl/bp_pkg.sv | 46 ++++
 rtl/rvc_expander.sv | 98 +++++++++
 rtl/bp_predecoder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared constants, FSM state type and RV32 instruction encoders for the fetch predecoder.
package bp_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] CTR_INIT = 2'b10;

  localparam logic [4:0] LINK_X1 = 5'd1;
  localparam logic [4:0] LINK_X5 = 5'd5;

  typedef enum logic {IDLE, WAIT} fsm_state_e;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_REG};
  endfunction

endpackage

// File: rtl/rvc_expander.sv
// Combinational RV32C to RV32I expander; illegal or unsupported encodings map to 32'b0.
module rvc_expander
  import bp_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] formalized_inst,
  output logic        rvc
);

  logic [15:0] c;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [5:0]  imm6;
  logic [11:0] imm6_sx;
  logic [9:0]  addi4spn_imm;
  logic [6:0]  lw_off;
  logic [9:0]  addi16sp_imm;
  logic [11:0] cj_off;
  logic [8:0]  cb_off;
  logic [7:0]  lwsp_off;
  logic [7:0]  swsp_off;

  assign c            = inst[15:0];
  assign rvc          = inst[1:0] != 2'b11;
  assign rd           = c[11:7];
  assign rs2          = c[6:2];
  assign rdp          = {2'b01, c[4:2]};
  assign rs1p         = {2'b01, c[9:7]};
  assign imm6         = {c[12], c[6:2]};
  assign imm6_sx      = {{6{c[12]}}, imm6};
  assign addi4spn_imm = {c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign lw_off       = {c[5], c[12:10], c[6], 2'b00};
  assign addi16sp_imm = {c[12], c[4:3], c[5], c[2], c[6], 4'b0000};
  assign cj_off       = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  assign cb_off       = {c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
  assign lwsp_off     = {c[3:2], c[12], c[6:4], 2'b00};
  assign swsp_off     = {c[8:7], c[12:9], 2'b00};

  always_comb begin
    formalized_inst = 32'b0;
    if (!rvc) begin
      formalized_inst = inst;
    end else begin
      case ({c[1:0], c[15:13]})
        5'b00_000: if (addi4spn_imm != 10'd0)
                     formalized_inst = enc_i({2'b00, addi4spn_imm}, 5'd2, 3'b000, rdp, OP_IMM);
        5'b00_010: formalized_inst = enc_i({5'b0, lw_off}, rs1p, 3'b010, rdp, OP_LOAD);
        5'b00_110: formalized_inst = enc_s({5'b0, lw_off}, rdp, rs1p, 3'b010);
        5'b01_000: formalized_inst = enc_i(imm6_sx, rd, 3'b000, rd, OP_IMM);
        5'b01_001: formalized_inst = enc_j({{9{c[12]}}, cj_off}, LINK_X1);
        5'b01_010: formalized_inst = enc_i(imm6_sx, 5'd0, 3'b000, rd, OP_IMM);
        5'b01_011: begin
          if (rd == 5'd2) begin
            if (addi16sp_imm != 10'd0)
              formalized_inst = enc_i({{2{c[12]}}, addi16sp_imm}, 5'd2, 3'b000, 5'd2, OP_IMM);
          end else if (imm6 != 6'd0 && rd != 5'd0) begin
            formalized_inst = {{14{c[12]}}, imm6, rd, OP_LUI};
          end
        end
        5'b01_100: begin
          case (c[11:10])
            2'b00: if (!c[12]) formalized_inst = enc_i({7'b0000000, c[6:2]}, rs1p, 3'b101, rs1p, OP_IMM);
            2'b01: if (!c[12]) formalized_inst = enc_i({7'b0100000, c[6:2]}, rs1p, 3'b101, rs1p, OP_IMM);
            2'b10: formalized_inst = enc_i(imm6_sx, rs1p, 3'b111, rs1p, OP_IMM);
            default: begin
              if (!c[12]) begin
                case (c[6:5])
                  2'b00:   formalized_inst = enc_r(7'b0100000, rdp, rs1p, 3'b000, rs1p);
                  2'b01:   formalized_inst = enc_r(7'b0000000, rdp, rs1p, 3'b100, rs1p);
                  2'b10:   formalized_inst = enc_r(7'b0000000, rdp, rs1p, 3'b110, rs1p);
                  default: formalized_inst = enc_r(7'b0000000, rdp, rs1p, 3'b111, rs1p);
                endcase
              end
            end
          endcase
        end
        5'b01_101: formalized_inst = enc_j({{9{c[12]}}, cj_off}, 5'd0);
        5'b01_110: formalized_inst = enc_b({{4{c[12]}}, cb_off}, 5'd0, rs1p, 3'b000);
        5'b01_111: formalized_inst = enc_b({{4{c[12]}}, cb_off}, 5'd0, rs1p, 3'b001);
        5'b10_000: if (!c[12]) formalized_inst = enc_i({7'b0000000, c[6:2]}, rd, 3'b001, rd, OP_IMM);
        5'b10_010: if (rd != 5'd0)
                     formalized_inst = enc_i({4'b0, lwsp_off}, 5'd2, 3'b010, rd, OP_LOAD);
        5'b10_100: begin
          // EBREAK (c12=1, rd=0, rs2=0) is outside the supported set and stays zero.
          if (!c[12]) begin
            if (rs2 != 5'd0)      formalized_inst = enc_r(7'b0, rs2, 5'd0, 3'b000, rd);
            else if (rd != 5'd0)  formalized_inst = enc_i(12'd0, rd, 3'b000, 5'd0, OP_JALR);
          end else begin
            if (rs2 != 5'd0)      formalized_inst = enc_r(7'b0, rs2, rd, 3'b000, rd);
            else if (rd != 5'd0)  formalized_inst = enc_i(12'd0, rd, 3'b000, LINK_X1, OP_JALR);
          end
        end
        5'b10_110: formalized_inst = enc_s({4'b0, swsp_off}, rs2, 5'd2, 3'b010);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bp_predecoder.sv
// Fetch predecoder: RVC expansion, BHT branch prediction, JALR wait FSM.
// Optional return-address stack enabled by defining BP_PREDECODER_RAS_EN.
module bp_predecoder
  import bp_pkg::*;
#(
  parameter int BHT_IDX_W = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic [31:0] inst_in,
  input  logic        inst_valid_in,
  input  logic [31:0] inst_addr_in,
  input  logic        rob_br_in,
  input  logic [31:0] rob_new_pc_in,
  input  logic [31:0] rob_imm_in,
  input  logic        upd_valid_in,
  input  logic [31:0] upd_pc_in,
  input  logic        upd_taken_in,
  output logic [31:0] next_pc_out,
  output logic [31:0] formalized_inst_out,
  output logic        rvc_out,
  output logic        pred_taken_out,
  output logic        stall_out
);

  localparam int BHT_SIZE = 1 << BHT_IDX_W;

  logic [1:0]           bht_q [BHT_SIZE];
  fsm_state_e           state_q;
  logic [BHT_IDX_W-1:0] rd_idx, upd_idx;
  logic [31:0]          len, jimm, bimm, ret_addr, ras_top;
  logic                 is_jal, is_jalr, is_branch, ras_hit, wait_entry;
  logic [1:0]           upd_ctr;
  logic                 unused_upd_bits;

  rvc_expander u_expander (
    .inst            (inst_in),
    .formalized_inst (formalized_inst_out),
    .rvc             (rvc_out)
  );

  assign is_jal    = formalized_inst_out[6:0] == OP_JAL;
  assign is_jalr   = formalized_inst_out[6:0] == OP_JALR;
  assign is_branch = formalized_inst_out[6:0] == OP_BRANCH;
  assign len       = rvc_out ? 32'd2 : 32'd4;
  assign ret_addr  = inst_addr_in + len;
  assign jimm = {{11{formalized_inst_out[31]}}, formalized_inst_out[31], formalized_inst_out[19:12],
                 formalized_inst_out[20], formalized_inst_out[30:21], 1'b0};
  assign bimm = {{19{formalized_inst_out[31]}}, formalized_inst_out[31], formalized_inst_out[7],
                 formalized_inst_out[30:25], formalized_inst_out[11:8], 1'b0};

  assign rd_idx          = inst_addr_in[BHT_IDX_W:1];
  assign upd_idx         = upd_pc_in[BHT_IDX_W:1];
  assign unused_upd_bits = ^{upd_pc_in[31:BHT_IDX_W+1], upd_pc_in[0]};
  assign pred_taken_out  = is_branch && inst_valid_in && bht_q[rd_idx][1];

  assign wait_entry = inst_valid_in && is_jalr && !rob_br_in && !clear_in && !ras_hit;
  assign stall_out  = (state_q == IDLE && wait_entry) || (state_q == WAIT && !rob_br_in);

  always_comb begin
    next_pc_out = ret_addr;
    if (rob_br_in)
      next_pc_out = rob_new_pc_in + rob_imm_in;
    else if (!inst_valid_in || state_q == WAIT)
      next_pc_out = inst_addr_in;
    else if (is_jal)
      next_pc_out = inst_addr_in + jimm;
    else if (is_branch)
      next_pc_out = pred_taken_out ? inst_addr_in + bimm : ret_addr;
    else if (is_jalr)
      next_pc_out = ras_hit ? ras_top : inst_addr_in;
  end

  // Saturating 2-bit counter step for the committed branch.
  always_comb begin
    upd_ctr = bht_q[upd_idx];
    if (upd_taken_in && upd_ctr != 2'b11)
      upd_ctr = upd_ctr + 2'b01;
    else if (!upd_taken_in && upd_ctr != 2'b00)
      upd_ctr = upd_ctr - 2'b01;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < BHT_SIZE; i++) bht_q[i] <= CTR_INIT;
    end else if (rdy_in && upd_valid_in) begin
      bht_q[upd_idx] <= upd_ctr;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)
      state_q <= IDLE;
    else if (rdy_in) begin
      if (state_q == IDLE && wait_entry)
        state_q <= WAIT;
      else if (state_q == WAIT && (rob_br_in || clear_in))
        state_q <= IDLE;
    end
  end

`ifdef BP_PREDECODER_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [31:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_pop, top_push;
  logic [PTR_W:0]   cnt_q, cnt_pop;
  logic [4:0]   inst_rd, inst_rs1;
  logic         rd_link, rs1_link, push_req, pop_req, ras_en, do_pop, do_push;

  assign inst_rd  = formalized_inst_out[11:7];
  assign inst_rs1 = formalized_inst_out[19:15];
  assign rd_link  = inst_rd == LINK_X1 || inst_rd == LINK_X5;
  assign rs1_link = inst_rs1 == LINK_X1 || inst_rs1 == LINK_X5;
  assign push_req = (is_jal || is_jalr) && rd_link;
  assign pop_req  = is_jalr && rs1_link && inst_rd != inst_rs1;
  assign ras_hit  = inst_valid_in && pop_req && cnt_q != '0 && state_q == IDLE;
  assign ras_top  = ras_q[top_q];

  // Stack only moves for a fresh instruction in IDLE; a held jalr in WAIT must not re-push.
  assign ras_en   = rdy_in && inst_valid_in && !rob_br_in && !clear_in && state_q == IDLE;
  assign do_pop   = ras_en && pop_req && cnt_q != '0;
  assign do_push  = ras_en && push_req;
  assign top_pop  = do_pop ? top_q - 1'b1 : top_q;
  assign cnt_pop  = cnt_q - {{PTR_W{1'b0}}, do_pop};
  assign top_push = top_pop + 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (rdy_in && (rob_br_in || clear_in)) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (do_push) begin
      top_q <= top_push;
      cnt_q <= (cnt_pop == (PTR_W+1)'(RAS_DEPTH)) ? cnt_pop : cnt_pop + 1'b1;
    end else begin
      top_q <= top_pop;
      cnt_q <= cnt_pop;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) ras_q[top_push] <= ret_addr;
  end
`else
  logic unused_ras_cfg;

  assign ras_hit        = 1'b0;
  assign ras_top        = 32'b0;
  assign unused_ras_cfg = ^RAS_DEPTH;
`endif

endmodule
